// File: rtl/ftf_pkg.sv
// Shared constants and types for the fixed-point to float converter.
// Optional FTF_ROUND_NEAREST_EN selects round-to-nearest-even packing.
package ftf_pkg;

    localparam int FIX_W      = 32;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 23;
    localparam int FLOAT_BIAS = 127;
    localparam int EXP_BASE   = FLOAT_BIAS + FIX_W - 1;

    // Lowest magnitude bit the packer consumes
`ifdef FTF_ROUND_NEAREST_EN
    localparam int FRAC_LSB = 0;
`else
    localparam int FRAC_LSB = 8;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ftf_pack.sv
// Combinational pack of normalized magnitude into IEEE-754 single.
// FTF_ROUND_NEAREST_EN adds round-to-nearest-even; otherwise truncates.
module ftf_pack
    import ftf_pkg::*;
(
    input  logic                     sign,
    input  logic [FIX_W-2:FRAC_LSB]  frac,
    input  logic [4:0]               cnt,
    input  logic [4:0]               fp,
    output logic [FIX_W-1:0]         result
);

    logic [EXP_W-1:0] exp_w;

    assign exp_w = EXP_W'(EXP_BASE) - {3'b000, cnt} - {3'b000, fp};

`ifdef FTF_ROUND_NEAREST_EN
    logic              guard;
    logic              sticky;
    logic              lsb;
    logic              inc;
    logic [MANT_W:0]   mant_sum;

    assign guard    = frac[7];
    assign sticky   = |frac[6:0];
    assign lsb      = frac[8];
    assign inc      = guard & (sticky | lsb);
    assign mant_sum = {1'b0, frac[FIX_W-2:8]} + (MANT_W+1)'(inc);

    // Mantissa carry-out wraps the fraction to zero and bumps the exponent
    assign result = {sign,
                     exp_w + EXP_W'(mant_sum[MANT_W]),
                     mant_sum[MANT_W-1:0]};
`else
    assign result = {sign, exp_w, frac[FIX_W-2:8]};
`endif

endmodule

// File: rtl/fixed_to_float_seq.sv
// Iterative 32-bit fixed-point to float converter, one shift per cycle.
// Build with FTF_ROUND_NEAREST_EN for round-to-nearest-even packing.
module fixed_to_float_seq
    import ftf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FIX_W-1:0]  fixed,
    input  logic [4:0]        fixpointpos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIX_W-1:0]  result
);

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic [FIX_W-1:0] mag_q, mag_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       fp_q, fp_d;
    logic [FIX_W-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [FIX_W-1:0] packed_w;
    logic             accept;
    logic             mag_zero;

    assign accept   = in_valid & in_ready;
    assign mag_zero = (mag_q == '0);

    ftf_pack u_pack (
        .sign   (sign_q),
        .frac   (mag_q[FIX_W-2:FRAC_LSB]),
        .cnt    (cnt_q),
        .fp     (fp_q),
        .result (packed_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Zero spends one NORM cycle so its latency matches the k=0 case
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)                state_d = NORM;
            NORM: if (mag_zero || mag_q[31])   state_d = DONE;
            DONE: if (out_ready)               state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    always_comb begin
        sign_d      = sign_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        fp_d        = fp_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d = fixed[31];
                    mag_d  = fixed[31] ? (~fixed + 32'd1) : fixed;
                    fp_d   = fixpointpos;
                    cnt_d  = 5'd0;
                end
            end
            NORM: begin
                if (mag_zero) begin
                    result_d    = '0;
                    out_valid_d = 1'b1;
                end else if (!mag_q[31]) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    result_d    = packed_w;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            fp_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            fp_q        <= fp_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Scoreboard bench for fixed_to_float_seq: directed vectors, queued
// expectations, and a negedge monitor checking result and latency.
module tb_fixed_to_float_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fixed;
    logic [4:0]  fixpointpos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          errors;
    int          cyc;
    logic        seen;
    logic [31:0] held;

`ifdef FTF_ROUND_NEAREST_EN
    localparam logic [31:0] EXP_1FFFFFF = 32'h4C000000;
    localparam logic [31:0] EXP_7FFFFFF = 32'h4F000000;
`else
    localparam logic [31:0] EXP_1FFFFFF = 32'h4BFFFFFF;
    localparam logic [31:0] EXP_7FFFFFF = 32'h4EFFFFFF;
`endif

    fixed_to_float_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fixed       (fixed),
        .fixpointpos (fixpointpos),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare each presented result against the queue head
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none",
                             result);
                end else begin
                    chk("result", result, sb[0].res);
                    chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
                seen = 1'b1;
                held = result;
            end else begin
                chk("hold_stable", result, held);
            end
            if (out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] f, input logic [4:0] fp,
                        input logic [31:0] res, input int lat,
                        input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid    = 1'b1;
        fixed       = f;
        fixpointpos = fp;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        e.res = res;
        e.acc = cyc + 1;
        e.lat = lat;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        fixed       = 32'hDEADBEEF;
        fixpointpos = 5'd9;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        seen        = 1'b0;
        held        = '0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        fixed       = '0;
        fixpointpos = '0;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'h0);
        rst = 1'b1;

        send(32'h00000001, 5'd0,  32'h3F800000, 32, 1);
        send(32'hFFFFFFFE, 5'd0,  32'hC0000000, 31, 1);
        send(32'h80000000, 5'd0,  32'hCF000000, 1,  1);
        send(32'h00018000, 5'd16, 32'h3FC00000, 16, 1);
        send(32'h00000000, 5'd7,  32'h00000000, 1,  1);
        send(32'h01FFFFFF, 5'd0,  EXP_1FFFFFF,  8,  1);
        send(32'h7FFFFFFF, 5'd0,  EXP_7FFFFFF,  2,  1);
        send(32'hFFFF8000, 5'd16, 32'hBF000000, 17, 1);
        drain();

        // Back-pressure: hold the consumer off while a second input waits
        out_ready = 1'b0;
        send(32'h00018000, 5'd16, 32'h3FC00000, 16, 1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
        in_valid    = 1'b1;
        fixed       = 32'h00000003;
        fixpointpos = 5'd0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid_high", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        send(32'h00000003, 5'd0, 32'h40400000, 31, 1);
        drain();

        // Reset during the fifth shift of a long normalization
        send(32'h00000001, 5'd0, 32'h3F800000, 32, 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        send(32'h00000003, 5'd0, 32'h40400000, 31, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
